// File: rtl/pool_window_scheduler_if.sv
// Handshake bundle between the pooling sequencer and its neighbours:
// pixel/start strobes in, line-buffer, max-tree and flat-buffer controls out.
interface pool_window_scheduler_if #(
    parameter int AW = 4
);
    logic          i_start;
    logic          i_in_valid;
    logic          o_lb_clear;
    logic          o_win_fire;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    modport master (
        output i_start,
        output i_in_valid,
        input  o_lb_clear,
        input  o_win_fire,
        input  o_wr_en,
        input  o_wr_addr,
        input  o_busy,
        input  o_done,
        input  o_err
    );

    modport slave (
        input  i_start,
        input  i_in_valid,
        output o_lb_clear,
        output o_win_fire,
        output o_wr_en,
        output o_wr_addr,
        output o_busy,
        output o_done,
        output o_err
    );
endinterface

// File: rtl/pool_window_scheduler.sv
// Frame sequencer for the lockstep 2x2/stride-2 max-pool datapath: counts the raster
// pixel stream, fires the max tree per window, and issues in-order flat-buffer writes.
module pool_window_scheduler #(
    parameter int IN_W     = 8,
    parameter int IN_H     = 8,
    parameter int POOL_K   = 2,
    parameter int POOL_LAT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    pool_window_scheduler_if.slave bus
);

    localparam int OUT_W = IN_W / POOL_K;
    localparam int OUT_N = OUT_W * (IN_H / POOL_K);
    localparam int AW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam int CW    = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW    = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int FW    = $clog2(POOL_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [FW-1:0] flush_q;
    logic          lb_clear_q;
    logic          err_q;

    logic          start_idle;
    logic          accept;
    logic          last_pix;
    logic          win_done;
    logic          flush_end;

    logic                          vld_p0;
    logic [AW-1:0]                 addr_p0;
    logic [POOL_LAT:1]             vld_pipe;
    logic [POOL_LAT:1][AW-1:0]     addr_pipe;

    // Row-major pooled index of the window whose bottom-right pixel is (r, c).
    function automatic logic [AW-1:0] win_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
        logic [31:0] idx;
        idx = 32'(r >> 1) * 32'(OUT_W) + 32'(c >> 1);
        return idx[AW-1:0];
    endfunction

    assign start_idle = (state_q == IDLE) && bus.i_start;
    assign accept     = (state_q == RUN) && bus.i_in_valid;
    assign last_pix   = accept && (row_q == RW'(IN_H - 1)) && (col_q == CW'(IN_W - 1));
    assign win_done   = accept && row_q[0] && col_q[0];
    assign flush_end  = (flush_q == FW'(POOL_LAT));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.i_start) state_d = RUN;
            RUN:     if (last_pix)    state_d = FLUSH;
            FLUSH:   if (flush_end)   state_d = DONE;
            DONE:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Control: state, raster counters, flush timer, clear pulse, sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            flush_q    <= '0;
            lb_clear_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lb_clear_q <= start_idle;

            if (start_idle || (state_q == DONE)) begin
                col_q <= '0;
                row_q <= '0;
            end else if (accept && !last_pix) begin
                if (col_q == CW'(IN_W - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end

            if (state_q == FLUSH) flush_q <= flush_q + 1'b1;
            else                  flush_q <= '0;

            // A dropped pixel wins over the clear when both arrive on the start cycle.
            if (bus.i_in_valid && (state_q != RUN)) err_q <= 1'b1;
            else if (start_idle)                    err_q <= 1'b0;
        end
    end

    // Stage p0: window fire and its pooled index, registered with the accepted pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            addr_p0 <= '0;
        end else begin
            vld_p0 <= win_done;
            if (win_done) addr_p0 <= win_addr(row_q, col_q);
        end
    end

    // Stages p1..pPOOL_LAT: track the max-tree latency; addresses only move with a valid
    // so the flat-buffer address holds between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[1] <= vld_p0;
            if (vld_p0) addr_pipe[1] <= addr_p0;
            for (int k = 2; k <= POOL_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) addr_pipe[k] <= addr_pipe[k-1];
            end
        end
    end

    assign bus.o_lb_clear = lb_clear_q;
    assign bus.o_win_fire = vld_p0;
    assign bus.o_wr_en    = vld_pipe[POOL_LAT];
    assign bus.o_wr_addr  = addr_pipe[POOL_LAT];
    assign bus.o_busy     = (state_q == RUN) || (state_q == FLUSH);
    assign bus.o_done     = (state_q == DONE);
    assign bus.o_err      = err_q;

endmodule
